// File: rtl/dmem_responder_if.sv
// Load/store request and response handshake between the core and the data memory.
interface dmem_responder_if #(
   parameter int WIDTH = 32
);
   logic             req_valid;
   logic             req_ready;
   logic [WIDTH-1:0] req_addr;
   logic             req_wr;
   logic [2:0]       req_memop;
   logic [WIDTH-1:0] req_wdata;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_rdata;
   logic             rsp_err;

   modport master (
      output req_valid, req_addr, req_wr, req_memop, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_addr, req_wr, req_memop, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: byte/half/word loads and stores, misaligned accesses split in two words.
//  state | meaning
//  IDLE  | ready for a request, classify on accept
//  ACC0  | access first word (widx)
//  ACC1  | access second word (widx+1) of a crossing access
//  RESP  | hold response until consumer accepts
module dmem_responder #(
   parameter int                WIDTH      = 32,
   parameter int                DEPTH_LOG2 = 10,
   parameter logic [WIDTH-1:0]  BASE       = 32'h8000_0000
) (
   input  logic             clk,
   input  logic             rst_n,
   dmem_responder_if.slave  bus
);
   typedef enum logic [1:0] {S_IDLE, S_ACC0, S_ACC1, S_RESP} state_t;

   state_t                  state_q, state_d;
   logic [DEPTH_LOG2-1:0]   widx_q;
   logic [1:0]              off_q;
   logic [2:0]              memop_q;
   logic                    wr_q, cross_q, err_q;
   logic [WIDTH-1:0]        wdata_q, buf0_q, buf1_q;

   logic [WIDTH-1:0]        rel;
   logic [DEPTH_LOG2-1:0]   widx_in, rd_idx;
   logic [2:0]              size_in;
   logic                    cross_in, err_in, accept;
   logic [3:0]              be4, wr_lanes;
   logic [7:0]              be8;
   logic [2*WIDTH-1:0]      wide;
   logic [WIDTH-1:0]        wr_bytes, rd_word, ld_word, ld_ext;

   logic [WIDTH-1:0]        mem [2**DEPTH_LOG2];

   assign accept = (state_q == S_IDLE) && bus.req_valid;

   always_comb begin
      rel     = bus.req_addr - BASE;
      widx_in = rel[DEPTH_LOG2+1:2];
      case (bus.req_memop[1:0])
         2'b00:   size_in = 3'd1;
         2'b01:   size_in = 3'd2;
         default: size_in = 3'd4;
      endcase
      cross_in = ({1'b0, rel[1:0]} + size_in) > 3'd4;
      err_in   = (bus.req_memop == 3'b011) || (bus.req_memop[2:1] == 2'b11)
              || (bus.req_memop[2] && bus.req_wr)
              || (|rel[WIDTH-1:DEPTH_LOG2+2])
              || (cross_in && (&widx_in));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (bus.req_valid) state_d = err_in ? S_RESP : S_ACC0;
         S_ACC0: state_d = cross_q ? S_ACC1 : S_RESP;
         S_ACC1: state_d = S_RESP;
         S_RESP: if (bus.rsp_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         widx_q  <= '0;
         off_q   <= '0;
         memop_q <= '0;
         wr_q    <= 1'b0;
         cross_q <= 1'b0;
         err_q   <= 1'b0;
         wdata_q <= '0;
         buf0_q  <= '0;
         buf1_q  <= '0;
      end else begin
         if (accept) begin
            widx_q  <= widx_in;
            off_q   <= rel[1:0];
            memop_q <= bus.req_memop;
            wr_q    <= bus.req_wr;
            cross_q <= cross_in;
            err_q   <= err_in;
            wdata_q <= bus.req_wdata;
         end
         if (state_q == S_ACC0) buf0_q <= rd_word;
         if (state_q == S_ACC1) buf1_q <= rd_word;
      end
   end

   // Widx+1 cannot wrap: a crossing access at the last word was rejected as an error.
   assign rd_idx  = (state_q == S_ACC1) ? widx_q + DEPTH_LOG2'(1) : widx_q;
   assign rd_word = mem[rd_idx];

   always_comb begin
      case (memop_q[1:0])
         2'b00:   be4 = 4'b0001;
         2'b01:   be4 = 4'b0011;
         default: be4 = 4'b1111;
      endcase
      be8      = {4'b0000, be4} << off_q;
      wide     = {{WIDTH{1'b0}}, wdata_q} << {off_q, 3'b000};
      wr_lanes = 4'b0000;
      wr_bytes = wide[WIDTH-1:0];
      if (wr_q && state_q == S_ACC0) wr_lanes = be8[3:0];
      if (wr_q && state_q == S_ACC1) begin
         wr_lanes = be8[7:4];
         wr_bytes = wide[2*WIDTH-1:WIDTH];
      end
   end

   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++)
         if (wr_lanes[b]) mem[rd_idx][8*b +: 8] <= wr_bytes[8*b +: 8];
   end

   always_comb begin
      ld_word = WIDTH'({buf1_q, buf0_q} >> {off_q, 3'b000});
      case (memop_q)
         3'b000:  ld_ext = {{(WIDTH-8){ld_word[7]}}, ld_word[7:0]};
         3'b001:  ld_ext = {{(WIDTH-16){ld_word[15]}}, ld_word[15:0]};
         3'b100:  ld_ext = {{(WIDTH-8){1'b0}}, ld_word[7:0]};
         3'b101:  ld_ext = {{(WIDTH-16){1'b0}}, ld_word[15:0]};
         default: ld_ext = ld_word;
      endcase
   end

   always_comb begin
      bus.req_ready = (state_q == S_IDLE);
      bus.rsp_valid = (state_q == S_RESP);
      bus.rsp_err   = (state_q == S_RESP) && err_q;
      bus.rsp_rdata = ((state_q == S_RESP) && !err_q && !wr_q) ? ld_ext : '0;
   end
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a byte-array reference model.
module tb_dmem_responder;
   localparam logic [31:0] BASE   = 32'h8000_0000;
   localparam int          DL2    = 10;
   localparam int          NBYTES = 4 << DL2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dmem_responder_if #(.WIDTH(32)) bus();

   dmem_responder #(.WIDTH(32), .DEPTH_LOG2(DL2), .BASE(BASE)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_errors = 0;
   logic [7:0] mdl [NBYTES];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   function automatic int msize(input logic [2:0] memop);
      return (memop[1:0] == 2'b00) ? 1 : (memop[1:0] == 2'b01) ? 2 : 4;
   endfunction

   function automatic bit mcross(input logic [31:0] addr, input logic [2:0] memop);
      logic [31:0] rel = addr - BASE;
      return (int'(rel % 4) + msize(memop)) > 4;
   endfunction

   function automatic bit merr(input bit wr, input logic [2:0] memop, input logic [31:0] addr);
      logic [31:0] rel = addr - BASE;
      if (memop == 3 || memop == 6 || memop == 7) return 1;
      if ((memop == 4 || memop == 5) && wr) return 1;
      if (rel >= NBYTES) return 1;
      if (mcross(addr, memop) && (rel / 4) == (NBYTES / 4 - 1)) return 1;
      return 0;
   endfunction

   function automatic logic [31:0] mload(input logic [2:0] memop, input logic [31:0] addr);
      logic [31:0] rel = addr - BASE;
      logic [31:0] v = 0;
      for (int i = 0; i < msize(memop); i++) v[8*i +: 8] = mdl[rel + i];
      if (memop == 0 && v[7])  v = v | 32'hFFFF_FF00;
      if (memop == 1 && v[15]) v = v | 32'hFFFF_0000;
      return v;
   endfunction

   task automatic mstore(input logic [2:0] memop, input logic [31:0] addr, input logic [31:0] wdata);
      logic [31:0] rel = addr - BASE;
      for (int i = 0; i < msize(memop); i++) mdl[rel + i] = wdata[8*i +: 8];
   endtask

   task automatic do_req(input bit wr, input logic [2:0] memop, input logic [31:0] addr,
                         input logic [31:0] wdata, input int stall,
                         output logic [31:0] rdata, output logic err, output int lat);
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_wr    = wr;
      bus.req_memop = memop;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      bus.rsp_ready = (stall == 0);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      lat = 1;
      while (!bus.rsp_valid && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      check("rsp_valid_seen", {31'b0, bus.rsp_valid}, 32'd1);
      rdata = bus.rsp_rdata;
      err   = bus.rsp_err;
      check("req_ready_busy", {31'b0, bus.req_ready}, 32'd0);
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         check("stall_valid", {31'b0, bus.rsp_valid}, 32'd1);
         check("stall_rdata", bus.rsp_rdata, rdata);
         check("stall_ready", {31'b0, bus.req_ready}, 32'd0);
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      check("idle_ready", {31'b0, bus.req_ready}, 32'd1);
      check("idle_valid", {31'b0, bus.rsp_valid}, 32'd0);
   endtask

   task automatic op(input bit wr, input logic [2:0] memop, input logic [31:0] addr,
                     input logic [31:0] wdata, input int stall,
                     output logic [31:0] rdata, output logic err, output int lat);
      bit          e_err = merr(wr, memop, addr);
      logic [31:0] e_rd  = (e_err || wr) ? 32'h0 : mload(memop, addr);
      int          e_lat = e_err ? 1 : (mcross(addr, memop) ? 3 : 2);
      do_req(wr, memop, addr, wdata, stall, rdata, err, lat);
      check("err", {31'b0, err}, {31'b0, e_err});
      check("rdata", rdata, e_rd);
      check("latency", 32'(lat), 32'(e_lat));
      if (!e_err && wr) mstore(memop, addr, wdata);
   endtask

   initial begin
      logic [31:0] r;
      logic        e;
      int          l;
      bus.req_valid = 1'b0;
      bus.req_wr    = 1'b0;
      bus.req_memop = 3'b000;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.rsp_ready = 1'b1;
      for (int i = 0; i < NBYTES; i++) mdl[i] = 8'h00;

      #12;
      check("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
      check("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
      check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
      check("rst_rsp_err",   {31'b0, bus.rsp_err}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      op(1, 3'b010, BASE, 32'h1122_3344, 0, r, e, l);
      check("sw_lat", 32'(l), 32'd2);
      op(0, 3'b010, BASE, 0, 0, r, e, l);
      check("lw_aligned", r, 32'h1122_3344);
      check("lw_lat", 32'(l), 32'd2);

      op(1, 3'b010, BASE, 32'h80F0_7F80, 0, r, e, l);
      op(0, 3'b000, BASE,     0, 0, r, e, l); check("lb",  r, 32'hFFFF_FF80);
      op(0, 3'b100, BASE,     0, 0, r, e, l); check("lbu", r, 32'h0000_0080);
      op(0, 3'b001, BASE + 2, 0, 0, r, e, l); check("lh",  r, 32'hFFFF_80F0);
      op(0, 3'b101, BASE + 2, 0, 0, r, e, l); check("lhu", r, 32'h0000_80F0);

      op(1, 3'b010, BASE,     32'hDDCC_BBAA, 0, r, e, l);
      op(1, 3'b010, BASE + 4, 32'h4433_2211, 0, r, e, l);
      op(0, 3'b010, BASE + 2, 0, 0, r, e, l);
      check("lw_cross", r, 32'h2211_DDCC);
      check("lw_cross_lat", 32'(l), 32'd3);
      op(1, 3'b001, BASE + 3, 32'h0000_BEEF, 0, r, e, l);
      op(0, 3'b010, BASE,     0, 0, r, e, l); check("sh_cross_w0", r, 32'hEFCC_BBAA);
      op(0, 3'b010, BASE + 4, 0, 0, r, e, l); check("sh_cross_w1", r, 32'h4433_22BE);

      op(0, 3'b111, BASE, 0, 0, r, e, l);
      check("err_memop7", {31'b0, e}, 32'd1);
      check("err_memop7_lat", 32'(l), 32'd1);
      op(1, 3'b100, BASE, 32'h1234_5678, 0, r, e, l);
      check("err_store_u", {31'b0, e}, 32'd1);
      op(0, 3'b010, BASE, 0, 0, r, e, l); check("err_no_write", r, 32'hEFCC_BBAA);
      op(1, 3'b010, BASE + NBYTES - 4, 32'h5A5A_5A5A, 0, r, e, l);
      op(0, 3'b010, BASE + NBYTES - 2, 0, 0, r, e, l);
      check("err_last_cross", {31'b0, e}, 32'd1);
      op(1, 3'b010, BASE + NBYTES - 2, 32'h1234_5678, 0, r, e, l);
      op(0, 3'b010, BASE + NBYTES - 4, 0, 0, r, e, l); check("err_last_nowr", r, 32'h5A5A_5A5A);

      op(0, 3'b010, BASE + NBYTES - 4, 0, 5, r, e, l);
      check("bp_rdata", r, 32'h5A5A_5A5A);

      // Crossing store interrupted by reset while in the second word access.
      op(1, 3'b010, BASE + 8,  32'h0102_0304, 0, r, e, l);
      op(1, 3'b010, BASE + 12, 32'h0506_0708, 0, r, e, l);
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_wr    = 1'b1;
      bus.req_memop = 3'b010;
      bus.req_addr  = BASE + 9;
      bus.req_wdata = 32'hA1B2_C3D4;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("midrst_req_ready", {31'b0, bus.req_ready}, 32'd1);
      check("midrst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
      check("midrst_rsp_rdata", bus.rsp_rdata, 32'd0);
      check("midrst_rsp_err",   {31'b0, bus.rsp_err}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      mdl[9] = 8'hD4; mdl[10] = 8'hC3; mdl[11] = 8'hB2;
      op(0, 3'b010, BASE + 8,  0, 0, r, e, l); check("midrst_w0", r, 32'hB2C3_D404);
      op(0, 3'b010, BASE + 12, 0, 0, r, e, l); check("midrst_w1", r, 32'h0506_0708);

      for (int w = 0; w <= 16; w++) op(1, 3'b010, BASE + 32'(4 * w), $urandom, 0, r, e, l);
      for (int w = NBYTES / 4 - 4; w < NBYTES / 4; w++)
         op(1, 3'b010, BASE + 32'(4 * w), $urandom, 0, r, e, l);

      for (int n = 0; n < 250; n++) begin
         int          kind = $urandom_range(0, 9);
         logic [31:0] rel;
         logic [2:0]  memop = 3'($urandom_range(0, 7));
         bit          wr = 1'($urandom_range(0, 1));
         int          stall = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
         if (kind < 6)      rel = $urandom_range(0, 63);
         else if (kind < 9) rel = NBYTES - 16 + $urandom_range(0, 15);
         else               rel = $urandom_range(NBYTES, NBYTES + 300);
         op(wr, memop, BASE + rel, $urandom, stall, r, e, l);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got=running exp=finished");
      $fatal(1);
   end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the RISC-V core: the memory-side end of the load/store interface driven by the decoder's `MemWr`/`MemOp` controls. It accepts one load or store per request handshake and performs byte-lane merging, sign/zero extension, and misaligned accesses that cross a word boundary (split into two word accesses). It owns a word-organised storage array with per-byte write enables and returns each result through a response handshake.

## Interface
- `WIDTH`, 32, address and data width.
- `DEPTH_LOG2`, 10, log2 of storage depth in 32-bit words.
- `BASE`, 32'h8000_0000, byte address of word 0.
- `clk` in 1, single clock, rising edge.
- `rst_n` in 1, reset, asynchronous assert, active-low.
- `req_valid` in 1, request present.
- `req_ready` out 1, responder can accept; high only in IDLE.
- `req_addr` in WIDTH, byte address.
- `req_wr` in 1, 1 = store, 0 = load (decoder `MemWr`).
- `req_memop` in 3, decoder `MemOp`: 000 byte signed / store byte, 001 half signed / store half, 010 word, 100 byte unsigned load, 101 half unsigned load.
- `req_wdata` in WIDTH, store data, low bytes used.
- `rsp_valid` out 1, response present.
- `rsp_ready` in 1, consumer accepts the response.
- `rsp_rdata` out WIDTH, extended load result; 0 for stores and errors.
- `rsp_err` out 1, request rejected.

## Operation
- States: IDLE, ACC0, ACC1, RESP.
- IDLE: `req_ready`=1. On `req_valid`, latch addr, wr, memop, and wdata, then classify:
  - Size: 1, 2, or 4 bytes.
  - Offset: `off = addr[1:0]`.
  - Word index: `widx = (addr-BASE)>>2`.
  - `cross = off+size>4`.
- Error, which goes IDLE→RESP with `rsp_err`=1, when any of the following holds:
  - memop is 011, 110, or 111.
  - memop is 100 or 101 with `req_wr`=1.
  - `addr-BASE` ≥ 4·2^DEPTH_LOG2.
  - `cross` and `widx` is the last word.
  - An errored request writes nothing.
- Otherwise go to ACC0.
- ACC0: access word `widx`.
  - Load: capture the word into buf0.
  - Store: write the byte lanes of `wdata<<(8·off)` that fall in word 0.
  - Next state is ACC1 if `cross`, else RESP.
- ACC1: access word `widx+1`.
  - Load: capture into buf1.
  - Store: write the remaining lanes, `wdata>>(8·(4-off))`, at lanes 0...
  - Next state is RESP.
- Load assembly: take `{buf1,buf0} >> (8·off)` (little-endian) and keep the low size bytes. Sign-extend for 000/001, zero-extend for 100/101; 010 needs none.
- RESP: `rsp_valid`=1; outputs stay stable until `rsp_ready`, then go to IDLE.
- Storage is not reset. Reads are combinational from a registered index and are captured at the end of the access cycle.

## Timing
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, buf0 and buf1 = 0.
- Latency is measured from the accept edge E to the first cycle with `rsp_valid`:
  - Error: 1 cycle.
  - Non-crossing access: 2 cycles.
  - Crossing access: 3 cycles.
- Stores become visible to a load accepted on any later edge.
- No overlap: `req_ready`=0 from accept until the cycle after response acceptance.
  - Max throughput is one aligned access per 3 cycles when `rsp_ready` is held at 1.
- `rsp_ready` held low: the responder stays in RESP indefinitely with outputs unchanged.
- `rsp_ready` high before `rsp_valid` has no effect.
- Reset mid-operation: return to IDLE immediately. A store lane already written in ACC0 remains; the ACC1 half is not performed. No response is issued.
- Width rules: `widx+1` is computed in `DEPTH_LOG2` bits after the range check, so it never wraps.

## Test plan
- Aligned word: store 32'h11223344 at BASE, then lw BASE → `rsp_rdata`=32'h11223344, `rsp_err`=0; each response arrives 2 cycles after accept.
- Byte/half extension, with the word at BASE = 32'h80F0_7F80:
  - lb BASE+0 → 32'hFFFFFF80
  - lbu BASE+0 → 32'h00000080
  - lh BASE+2 → 32'hFFFF80F0
  - lhu BASE+2 → 32'h000080F0
- Misaligned crossing: with words 32'hDDCCBBAA and 32'h44332211 at BASE and BASE+4:
  - lw BASE+2 → 32'h2211DDCC, 3-cycle latency.
  - sh 16'hBEEF at BASE+3 → words become 32'hEFCCBBAA and 32'h443322BE.
- Errors:
  - memop 3'b111 → `rsp_err`=1 after 1 cycle.
  - memop 100 with `req_wr`=1 → `rsp_err`=1.
  - lw at BASE+4·2^DEPTH_LOG2-2 → `rsp_err`=1; storage unchanged in all error cases.
- Backpressure: hold `rsp_ready`=0 for 5 cycles in RESP → `rsp_valid` and `rsp_rdata` stable and `req_ready`=0; release → IDLE the next cycle.
- Reset mid-operation: assert `rst_n`=0 during ACC1 of a crossing store → outputs return to reset values asynchronously; the ACC0 lanes are written and the ACC1 lanes are unchanged.
